// File: rtl/screen_mem_scheduler_pkg.sv
// Purpose: shared constants and types for the screen RAM time-slot scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package screen_mem_pkg;

    // Phase values at which each slot action happens (named by ph before the edge).
    localparam logic [2:0] PH_VID_ADDR   = 3'd7;
    localparam logic [2:0] PH_VID_LATCH  = 3'd1;
    localparam logic [2:0] PH_CPU_ADDR   = 3'd3;
    localparam logic [2:0] PH_CPU_WE_END = 3'd4;
    localparam logic [2:0] PH_CPU_LATCH  = 3'd5;

    // Screen-size select driven by the system VIA.
    typedef enum logic [1:0] {
        SCROLL_20K = 2'b00,
        SCROLL_16K = 2'b01,
        SCROLL_10K = 2'b10,
        SCROLL_8K  = 2'b11
    } scroll_sel_t;

    // Offset added when the CRTC address runs past the top of RAM (MA[12]=1).
    localparam logic [14:0] WRAP_ADJ_20K = 15'h3000;
    localparam logic [14:0] WRAP_ADJ_16K = 15'h4000;
    localparam logic [14:0] WRAP_ADJ_10K = 15'h5800;
    localparam logic [14:0] WRAP_ADJ_8K  = 15'h6000;

    // CPU slot sequencing.
    typedef enum logic [1:0] {
        CPU_IDLE  = 2'd0,
        CPU_READ  = 2'd1,
        CPU_WRITE = 2'd2,
        CPU_ACK   = 2'd3
    } cpu_state_t;

    function automatic logic [14:0] wrap_adjust(input scroll_sel_t sel);
        logic [14:0] adj;
        case (sel)
            SCROLL_20K: adj = WRAP_ADJ_20K;
            SCROLL_16K: adj = WRAP_ADJ_16K;
            SCROLL_10K: adj = WRAP_ADJ_10K;
            default:    adj = WRAP_ADJ_8K;
        endcase
        return adj;
    endfunction

endpackage

// File: rtl/screen_mem_scheduler_if.sv
// Purpose: bundles CRTC, CPU handshake, RAM port and video output signals.
// Latency: n/a (wiring only).
// Backpressure: CPU side uses req/ack; RAM and video sides are fixed-slot, no stall.
interface screen_mem_scheduler_if;
    logic [13:0] crtc_ma;
    logic [2:0]  crtc_ra;
    logic [1:0]  scroll_sel;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  vid_data;
    logic        vid_strobe;

    // Scheduler side.
    modport slave (
        input  crtc_ma, crtc_ra, scroll_sel,
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output vid_data, vid_strobe
    );

    // Environment side (CRTC, CPU, RAM, Video ULA).
    modport master (
        output crtc_ma, crtc_ra, scroll_sel,
        output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  vid_data, vid_strobe
    );
endinterface

// File: rtl/screen_mem_scheduler_xlate.sv
// Purpose: CRTC MA/RA to RAM address, with hardware-scroll wrap and teletext window.
// Latency: combinational.
// Backpressure: none.
module screen_addr_xlate
    import screen_mem_pkg::*;
(
    input  logic [13:0] i_crtc_ma,
    input  logic [2:0]  i_crtc_ra,
    input  scroll_sel_t i_scroll_sel,
    output logic [14:0] o_addr
);

    logic [14:0] w_raw;
    assign w_raw = {i_crtc_ma[11:0], i_crtc_ra};

    // Teletext window wins; otherwise bitmap address, wrapped back into screen when MA[12] set.
    always_comb begin
        o_addr = w_raw;
        if (i_crtc_ma[13]) begin
            o_addr = {5'b11111, i_crtc_ma[9:0]};
        end else if (i_crtc_ma[12]) begin
            o_addr = w_raw + wrap_adjust(i_scroll_sel);
        end
    end

endmodule

// File: rtl/screen_mem_scheduler.sv
// Purpose: 8-phase slot scheduler sharing one RAM port between video fetch and 6502 access.
// Latency: video byte 3 cycles after address issue; CPU ack 3..10 cycles after request.
// Backpressure: CPU held off via req/ack until its ph3 sample; video slot never stalls.
module screen_mem_scheduler
    import screen_mem_pkg::*;
(
    input  logic                   clk16MHz,
    input  logic                   nRESET,
    screen_mem_scheduler_if.slave  bus
);

    logic [2:0]  r_ph;
    logic [14:0] r_ram_addr;
    logic        r_ram_we;
    logic [7:0]  r_ram_wdata;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_vid_data;
    logic        r_vid_strobe;
    logic        r_vid_armed;
    cpu_state_t  r_cpu_st;
    cpu_state_t  w_cpu_nxt;
    logic        w_cpu_start;
    logic [14:0] w_vid_addr;

    screen_addr_xlate u_xlate (
        .i_crtc_ma    (bus.crtc_ma),
        .i_crtc_ra    (bus.crtc_ra),
        .i_scroll_sel (scroll_sel_t'(bus.scroll_sel)),
        .o_addr       (w_vid_addr)
    );

    // Free-running phase counter, one wrap per 2 MHz period.
    always_ff @(posedge clk16MHz or negedge nRESET) begin
        if (!nRESET) r_ph <= 3'd0;
        else         r_ph <= r_ph + 3'd1;
    end

    // CPU request is only ever sampled at the ph3 edge.
    assign w_cpu_start = (r_cpu_st == CPU_IDLE) && (r_ph == PH_CPU_ADDR) && bus.cpu_req;

    // CPU slot state register.
    always_ff @(posedge clk16MHz or negedge nRESET) begin
        if (!nRESET) r_cpu_st <= CPU_IDLE;
        else         r_cpu_st <= w_cpu_nxt;
    end

    // CPU slot next state: access in flight ph4..ph5, ack during ph6.
    always_comb begin
        w_cpu_nxt = r_cpu_st;
        case (r_cpu_st)
            CPU_IDLE:  if (w_cpu_start) w_cpu_nxt = bus.cpu_rnw ? CPU_READ : CPU_WRITE;
            CPU_READ,
            CPU_WRITE: if (r_ph == PH_CPU_LATCH) w_cpu_nxt = CPU_ACK;
            CPU_ACK:   w_cpu_nxt = CPU_IDLE;
            default:   w_cpu_nxt = CPU_IDLE;
        endcase
    end

    // RAM port: video address at ph7, CPU address/data at ph3, write strobe cut at ph4.
    always_ff @(posedge clk16MHz or negedge nRESET) begin
        if (!nRESET) begin
            r_ram_addr  <= 15'd0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 8'd0;
        end else begin
            if (r_ph == PH_VID_ADDR) begin
                r_ram_addr <= w_vid_addr;
            end else if (w_cpu_start) begin
                r_ram_addr  <= bus.cpu_addr;
                r_ram_wdata <= bus.cpu_wdata;
            end
            if (w_cpu_start)                  r_ram_we <= ~bus.cpu_rnw;
            else if (r_ph == PH_CPU_WE_END)   r_ram_we <= 1'b0;
        end
    end

    // CPU read data captured at ph5; writes leave it untouched.
    always_ff @(posedge clk16MHz or negedge nRESET) begin
        if (!nRESET)                                             r_cpu_rdata <= 8'd0;
        else if ((r_cpu_st == CPU_READ) && (r_ph == PH_CPU_LATCH)) r_cpu_rdata <= bus.ram_rdata;
    end

    // Video latch at ph1; suppressed until a real video address has been issued after reset.
    always_ff @(posedge clk16MHz or negedge nRESET) begin
        if (!nRESET) begin
            r_vid_armed  <= 1'b0;
            r_vid_data   <= 8'd0;
            r_vid_strobe <= 1'b0;
        end else begin
            if (r_ph == PH_VID_ADDR) r_vid_armed <= 1'b1;
            r_vid_strobe <= (r_ph == PH_VID_LATCH) && r_vid_armed;
            if ((r_ph == PH_VID_LATCH) && r_vid_armed) r_vid_data <= bus.ram_rdata;
        end
    end

    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_ack    = (r_cpu_st == CPU_ACK);
    assign bus.vid_data   = r_vid_data;
    assign bus.vid_strobe = r_vid_strobe;

endmodule
